di_packer: RTL and testbench
============================

DI_PACKER -- requirements
Module: di_packer

Interface
REQ-001 Parameter DI_DATA_WIDTH, default 32, word-side data width; SHALL be 16, 32 or 64.
REQ-002 Parameter SUB_WIDTH, default 8, narrow-side data width; SHALL be 8 or 16 and divide DI_DATA_WIDTH; RATIO = DI_DATA_WIDTH/SUB_WIDTH >= 2.
REQ-003 Parameter BIG_ENDIAN, default 0; 0 = slice 0 is bits [SUB_WIDTH-1:0], 1 = slice 0 is the most-significant slice.
REQ-004 ifclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  block enable; low forces mode-exit clear.
REQ-007 di0_len  in  32  transfer length in sub-words.
REQ-008 di0_write_mode, di0_read_mode  in  1 each  transfer direction; both high = read.
REQ-009 di0_write  in  1  word-write strobe; di0_reg_datai  in  DI_DATA_WIDTH  write word; di0_write_rdy  out  1  word accepted when high.
REQ-010 di0_read_req  in  1  word-read request; di0_read  in  1  word consumed; di0_reg_datao  out  DI_DATA_WIDTH  assembled word; di0_read_rdy  out  1  word valid.
REQ-011 di1_write  out  1  sub-word strobe; di1_reg_datai  out  SUB_WIDTH; di1_write_rdy  in  1  sink can take a sub-word next cycle.
REQ-012 di1_read_req  out  1; di1_read  out  1  sub-word strobe; di1_reg_datao  in  SUB_WIDTH; di1_read_rdy  in  1.
REQ-013 xfer_count  out  32  sub-words moved since mode entry; xfer_done  out  1  high when xfer_count == di0_len and di0_len != 0.

Function
REQ-014 States: IDLE, WSHIFT, RSHIFT, RVALID; registers: word sr, slice index pos (0..RATIO-1), xfer_count.
REQ-015 Mode-exit clear (enable low, or neither mode high), synchronous: state IDLE, pos 0, xfer_count 0, sr 0, all strobes/req low, di0_read_rdy 0; di0_write_rdy follows di1_write_rdy one cycle later.
REQ-016 Write, IDLE: di0_write_rdy = registered di1_write_rdy; di0_write while di0_write_rdy high latches di0_reg_datai into sr, pos 0, goes WSHIFT, drops di0_write_rdy next cycle; di0_write while di0_write_rdy low is ignored.
REQ-017 Write, WSHIFT: di1_write is registered; set high for a cycle iff di1_write_rdy high at the prior edge and sub-words remain; back-to-back strobes permitted.
REQ-018 di1_reg_datai = slice pos of sr per BIG_ENDIAN, combinationally valid while di1_write high; each di1_write cycle increments pos and xfer_count.
REQ-019 WSHIFT exits to IDLE, di0_write_rdy 1, after the strobe for slice RATIO-1 or the strobe making xfer_count == di0_len, whichever first; no further di1_write.
REQ-020 Read, IDLE: di0_read_req with xfer_count < di0_len clears sr, pos 0, sets di1_read_req, goes RSHIFT; otherwise request ignored.
REQ-021 Read, RSHIFT: di1_read registered, high one cycle iff di1_read_rdy high at prior edge and sub-words remain; di1_reg_datao sampled into slice pos on edge ending a di1_read cycle; pos and xfer_count increment.
REQ-022 RSHIFT exits to RVALID after the sample completing slice RATIO-1 or reaching di0_len; di1_read_req drops same edge; unfilled slices remain 0.
REQ-023 RVALID: di0_read_rdy 1, di0_reg_datao = sr stable; di0_read drops di0_read_rdy combinationally, state IDLE next edge.
REQ-024 di0_len = 0: write word accepted and discarded, no di1_write, WSHIFT exits next edge; read requests ignored.
REQ-025 xfer_count saturates at di0_len; never wraps; mode change mid-word abandons the word via REQ-015.

Reset
REQ-026 While reset high: all outputs 0, state IDLE, sr 0, pos 0, xfer_count 0; outputs valid cycle after reset deasserts.
REQ-027 Reset asserted mid-transfer aborts immediately without further strobes.

Verification
REQ-028 32/8, LE, di0_len=4, write 0x44332211, di1_write_rdy held 1 -> 4 consecutive di1_write, data 11,22,33,44; di0_write_rdy back 1; xfer_done 1.
REQ-029 32/8, BE, same word -> data 44,33,22,11.
REQ-030 32/8, LE, read, di0_len=6, di1 supplies A1..A6 -> word1 0xA4A3A2A1, word2 0x0000A6A5; third di0_read_req ignored.
REQ-031 64/16, write, di1_write_rdy toggled 1,0 -> strobes only after rdy-high edges, 4 slices in order, no drop or duplicate.
REQ-032 Write mid-word, enable pulled low -> strobes stop next edge, xfer_count 0; re-enable and new word starts at slice 0.
REQ-033 Reset asserted during RSHIFT -> di1_read_req, di1_read, di0_read_rdy low immediately; di0_len=0 write -> zero di1_write strobes.

Source files
------------

// File: rtl/di_packer.sv
// Word-to-sub-word packer: splits a DI_DATA_WIDTH word into SUB_WIDTH slices on
// writes, and assembles SUB_WIDTH slices into a word on reads.
module di_packer #(
  parameter int unsigned DI_DATA_WIDTH = 32,
  parameter int unsigned SUB_WIDTH     = 8,
  parameter bit          BIG_ENDIAN    = 1'b0
) (
  input  logic                     ifclk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              di0_len,
  input  logic                     di0_write_mode,
  input  logic                     di0_read_mode,
  input  logic                     di0_write,
  input  logic [DI_DATA_WIDTH-1:0] di0_reg_datai,
  output logic                     di0_write_rdy,
  input  logic                     di0_read_req,
  input  logic                     di0_read,
  output logic [DI_DATA_WIDTH-1:0] di0_reg_datao,
  output logic                     di0_read_rdy,
  output logic                     di1_write,
  output logic [SUB_WIDTH-1:0]     di1_reg_datai,
  input  logic                     di1_write_rdy,
  output logic                     di1_read_req,
  output logic                     di1_read,
  input  logic [SUB_WIDTH-1:0]     di1_reg_datao,
  input  logic                     di1_read_rdy,
  output logic [31:0]              xfer_count,
  output logic                     xfer_done
);

  localparam int unsigned RATIO = DI_DATA_WIDTH / SUB_WIDTH;
  localparam int unsigned POS_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, WSHIFT, RSHIFT, RVALID} state_t;

  state_t                   state, state_d;
  logic [DI_DATA_WIDTH-1:0] sr, sr_d;
  logic [POS_W-1:0]         pos, pos_d, slice_idx;
  logic [31:0]              cnt, cnt_d, cnt_inc;
  logic                     wr_rdy_q, wr_rdy_d;
  logic                     di1_write_q, di1_write_d;
  logic                     di1_read_q, di1_read_d;
  logic                     rreq_q, rreq_d;
  logic                     remain, last_beat, mode_exit;

  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      pos         <= '0;
      cnt         <= '0;
      wr_rdy_q    <= 1'b0;
      di1_write_q <= 1'b0;
      di1_read_q  <= 1'b0;
      rreq_q      <= 1'b0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      pos         <= pos_d;
      cnt         <= cnt_d;
      wr_rdy_q    <= wr_rdy_d;
      di1_write_q <= di1_write_d;
      di1_read_q  <= di1_read_d;
      rreq_q      <= rreq_d;
    end
  end

  // Slice position in sr for the current beat, honouring byte order
  assign slice_idx = BIG_ENDIAN ? POS_W'(POS_LAST - pos) : pos;
  assign cnt_inc   = cnt + 32'd1;
  assign remain    = (cnt < di0_len);
  assign last_beat = (pos == POS_LAST) || (cnt_inc == di0_len);

  // Switching direction mid-word abandons the word the same way as leaving both modes
  always_comb begin
    mode_exit = !enable || !(di0_write_mode || di0_read_mode);
    if ((state == WSHIFT) && di0_read_mode) mode_exit = 1'b1;
    if (((state == RSHIFT) || (state == RVALID)) && !di0_read_mode) mode_exit = 1'b1;
  end

  always_comb begin
    state_d     = state;
    sr_d        = sr;
    pos_d       = pos;
    cnt_d       = cnt;
    wr_rdy_d    = 1'b0;
    di1_write_d = 1'b0;
    di1_read_d  = 1'b0;
    rreq_d      = 1'b0;
    if (mode_exit) begin
      state_d  = IDLE;
      sr_d     = '0;
      pos_d    = '0;
      cnt_d    = '0;
      wr_rdy_d = di1_write_rdy;
    end else begin
      case (state)
        IDLE: begin
          if (di0_read_mode) begin
            if (di0_read_req && remain) begin
              sr_d    = '0;
              pos_d   = '0;
              rreq_d  = 1'b1;
              state_d = RSHIFT;
            end
          end else if (di0_write && wr_rdy_q) begin
            sr_d    = di0_reg_datai;
            pos_d   = '0;
            state_d = WSHIFT;
          end else begin
            wr_rdy_d = di1_write_rdy;
          end
        end
        WSHIFT: begin
          if (di1_write_q) begin
            pos_d = pos + POS_W'(1);
            cnt_d = remain ? cnt_inc : cnt;
            if (last_beat) begin
              state_d  = IDLE;
              pos_d    = '0;
              wr_rdy_d = 1'b1;
            end else begin
              di1_write_d = di1_write_rdy;
            end
          end else if (!remain) begin
            state_d  = IDLE;
            pos_d    = '0;
            wr_rdy_d = 1'b1;
          end else begin
            di1_write_d = di1_write_rdy;
          end
        end
        RSHIFT: begin
          rreq_d = 1'b1;
          if (di1_read_q) begin
            sr_d[slice_idx*SUB_WIDTH +: SUB_WIDTH] = di1_reg_datao;
            pos_d = pos + POS_W'(1);
            cnt_d = remain ? cnt_inc : cnt;
            if (last_beat) begin
              state_d = RVALID;
              pos_d   = '0;
              rreq_d  = 1'b0;
            end else begin
              di1_read_d = di1_read_rdy;
            end
          end else if (!remain) begin
            state_d = RVALID;
            pos_d   = '0;
            rreq_d  = 1'b0;
          end else begin
            di1_read_d = di1_read_rdy;
          end
        end
        RVALID: begin
          if (di0_read) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign di0_write_rdy = wr_rdy_q;
  assign di1_write     = di1_write_q;
  assign di1_read      = di1_read_q;
  assign di1_read_req  = rreq_q;
  assign di1_reg_datai = di1_write_q ? sr[slice_idx*SUB_WIDTH +: SUB_WIDTH] : '0;
  assign di0_reg_datao = sr;
  // Word handshake drops in the same cycle the consumer takes it
  assign di0_read_rdy  = (state == RVALID) && !di0_read;
  assign xfer_count    = cnt;
  assign xfer_done     = (cnt == di0_len) && (di0_len != 32'd0);

endmodule

// File: tb/tb_di_packer.sv
// Directed bench for di_packer: 32/8 little- and big-endian instances in lockstep
// plus a 64/16 instance sharing the control inputs.
module tb_di_packer;

  logic        ifclk = 1'b0;
  logic        reset;
  logic        enable, wmode, rmode, di0_write, di0_read_req, di0_read;
  logic        di1_write_rdy, di1_read_rdy;
  logic [31:0] di0_len, wdata32;
  logic [63:0] wdata64;
  logic [7:0]  rd_idx, di1_datao;
  logic [15:0] w_di1_datao;

  logic        le_wrdy, le_rrdy, le_d1w, le_rreq, le_d1r, le_done;
  logic [31:0] le_datao, le_cnt;
  logic [7:0]  le_d1i;
  logic        be_wrdy, be_rrdy, be_d1w, be_rreq, be_d1r, be_done;
  logic [31:0] be_datao, be_cnt;
  logic [7:0]  be_d1i;
  logic        w_wrdy, w_rrdy, w_d1w, w_rreq, w_d1r, w_done;
  logic [63:0] w_datao;
  logic [31:0] w_cnt;
  logic [15:0] w_d1i;

  int total = 0;
  int bad   = 0;

  always #5 ifclk = ~ifclk;

  // Read-side source: supplies 0xA1, 0xA2, ... one per di1_read beat
  assign di1_datao   = 8'hA1 + rd_idx;
  assign w_di1_datao = {8'h00, di1_datao};
  always @(posedge ifclk or posedge reset) begin
    if (reset) rd_idx <= 8'h00;
    else if (le_d1r) rd_idx <= rd_idx + 8'h01;
  end

  di_packer #(.DI_DATA_WIDTH(32), .SUB_WIDTH(8), .BIG_ENDIAN(1'b0)) u_le (
    .ifclk(ifclk), .reset(reset), .enable(enable), .di0_len(di0_len),
    .di0_write_mode(wmode), .di0_read_mode(rmode), .di0_write(di0_write),
    .di0_reg_datai(wdata32), .di0_write_rdy(le_wrdy), .di0_read_req(di0_read_req),
    .di0_read(di0_read), .di0_reg_datao(le_datao), .di0_read_rdy(le_rrdy),
    .di1_write(le_d1w), .di1_reg_datai(le_d1i), .di1_write_rdy(di1_write_rdy),
    .di1_read_req(le_rreq), .di1_read(le_d1r), .di1_reg_datao(di1_datao),
    .di1_read_rdy(di1_read_rdy), .xfer_count(le_cnt), .xfer_done(le_done));

  di_packer #(.DI_DATA_WIDTH(32), .SUB_WIDTH(8), .BIG_ENDIAN(1'b1)) u_be (
    .ifclk(ifclk), .reset(reset), .enable(enable), .di0_len(di0_len),
    .di0_write_mode(wmode), .di0_read_mode(rmode), .di0_write(di0_write),
    .di0_reg_datai(wdata32), .di0_write_rdy(be_wrdy), .di0_read_req(di0_read_req),
    .di0_read(di0_read), .di0_reg_datao(be_datao), .di0_read_rdy(be_rrdy),
    .di1_write(be_d1w), .di1_reg_datai(be_d1i), .di1_write_rdy(di1_write_rdy),
    .di1_read_req(be_rreq), .di1_read(be_d1r), .di1_reg_datao(di1_datao),
    .di1_read_rdy(di1_read_rdy), .xfer_count(be_cnt), .xfer_done(be_done));

  di_packer #(.DI_DATA_WIDTH(64), .SUB_WIDTH(16), .BIG_ENDIAN(1'b0)) u_w (
    .ifclk(ifclk), .reset(reset), .enable(enable), .di0_len(di0_len),
    .di0_write_mode(wmode), .di0_read_mode(rmode), .di0_write(di0_write),
    .di0_reg_datai(wdata64), .di0_write_rdy(w_wrdy), .di0_read_req(di0_read_req),
    .di0_read(di0_read), .di0_reg_datao(w_datao), .di0_read_rdy(w_rrdy),
    .di1_write(w_d1w), .di1_reg_datai(w_d1i), .di1_write_rdy(di1_write_rdy),
    .di1_read_req(w_rreq), .di1_read(w_d1r), .di1_reg_datao(w_di1_datao),
    .di1_read_rdy(di1_read_rdy), .xfer_count(w_cnt), .xfer_done(w_done));

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_modes();
    wmode = 1'b0;
    rmode = 1'b0;
    tick();
  endtask

  logic [7:0]  le_exp [4];
  logic [7:0]  be_exp [4];
  logic        prev_rdy;
  int          nstrobe;

  initial begin
    reset = 1'b1; enable = 1'b0; wmode = 1'b0; rmode = 1'b0;
    di0_write = 1'b0; di0_read_req = 1'b0; di0_read = 1'b0;
    di1_write_rdy = 1'b1; di1_read_rdy = 1'b0;
    di0_len = 32'd0; wdata32 = 32'h0; wdata64 = 64'h0;
    le_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    be_exp = '{8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick();
    chk("rst_wrdy", le_wrdy, 1'b0);
    chk("rst_d1w", le_d1w, 1'b0);
    chk("rst_rrdy", le_rrdy, 1'b0);
    chk("rst_cnt", le_cnt, 32'd0);

    // Write 0x44332211, len 4, sink always ready
    enable = 1'b1; wmode = 1'b1; di0_len = 32'd4; wdata32 = 32'h44332211;
    wdata64 = 64'h4444_3333_2222_1111;
    reset = 1'b0;
    tick();
    chk("wr_rdy_idle", le_wrdy, 1'b1);
    di0_write = 1'b1;
    tick();
    di0_write = 1'b0;
    chk("wr_rdy_busy", le_wrdy, 1'b0);
    chk("wr_no_early_strobe", le_d1w, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("le_strobe%0d", i), le_d1w, 1'b1);
      chk($sformatf("le_data%0d", i), le_d1i, le_exp[i]);
      chk($sformatf("be_data%0d", i), be_d1i, be_exp[i]);
    end
    tick();
    chk("wr_end_strobe", le_d1w, 1'b0);
    chk("wr_end_rdy", le_wrdy, 1'b1);
    chk("wr_end_cnt", le_cnt, 32'd4);
    chk("wr_end_done", le_done, 1'b1);

    // Read 6 sub-words: two words, the second partially filled
    clear_modes();
    rmode = 1'b1; di0_len = 32'd6; di1_read_rdy = 1'b1;
    tick();
    di0_read_req = 1'b1;
    tick();
    di0_read_req = 1'b0;
    chk("rd_req_up", le_rreq, 1'b1);
    chk("rd_no_early_read", le_d1r, 1'b0);
    repeat (5) tick();
    chk("rd1_rdy", le_rrdy, 1'b1);
    chk("rd1_req_down", le_rreq, 1'b0);
    chk("rd1_le_word", le_datao, 32'hA4A3A2A1);
    chk("rd1_be_word", be_datao, 32'hA1A2A3A4);
    chk("rd1_cnt", le_cnt, 32'd4);
    chk("rd1_done", le_done, 1'b0);
    di0_read = 1'b1;
    #1;
    chk("rd1_rdy_drop", le_rrdy, 1'b0);
    tick();
    di0_read = 1'b0;
    di0_read_req = 1'b1;
    tick();
    di0_read_req = 1'b0;
    repeat (3) tick();
    chk("rd2_rdy", le_rrdy, 1'b1);
    chk("rd2_le_word", le_datao, 32'h0000A6A5);
    chk("rd2_be_word", be_datao, 32'hA5A60000);
    chk("rd2_done", le_done, 1'b1);
    di0_read = 1'b1;
    tick();
    di0_read = 1'b0;
    di0_read_req = 1'b1;
    tick();
    di0_read_req = 1'b0;
    chk("rd3_ignored", le_rreq, 1'b0);
    chk("rd3_cnt_sat", le_cnt, 32'd6);

    // 64/16 write with a sink that is ready every other cycle
    clear_modes();
    di1_read_rdy = 1'b0; wmode = 1'b1; di0_len = 32'd4; di1_write_rdy = 1'b1;
    tick();
    di0_write = 1'b1;
    tick();
    di0_write = 1'b0;
    nstrobe = 0;
    for (int i = 0; i < 16; i++) begin
      di1_write_rdy = (i % 2 == 0);
      prev_rdy = di1_write_rdy;
      tick();
      if (w_d1w) begin
        chk($sformatf("w_gate%0d", nstrobe), prev_rdy, 1'b1);
        chk($sformatf("w_data%0d", nstrobe), w_d1i, 16'h1111 * 16'(nstrobe + 1));
        nstrobe++;
      end
    end
    chk("w_strobes", nstrobe, 4);
    chk("w_cnt", w_cnt, 32'd4);
    chk("w_done", w_done, 1'b1);

    // Enable dropped mid-word, then a fresh word restarts at slice 0
    clear_modes();
    wmode = 1'b1; di0_len = 32'd8; di1_write_rdy = 1'b1;
    tick();
    di0_write = 1'b1;
    tick();
    di0_write = 1'b0;
    tick();
    chk("en_s0", le_d1i, 8'h11);
    tick();
    chk("en_s1", le_d1i, 8'h22);
    chk("en_cnt1", le_cnt, 32'd1);
    enable = 1'b0;
    tick();
    chk("en_off_strobe", le_d1w, 1'b0);
    chk("en_off_cnt", le_cnt, 32'd0);
    enable = 1'b1; wdata32 = 32'hDDCCBBAA; di0_write = 1'b1;
    tick();
    di0_write = 1'b0;
    tick();
    chk("en_new_strobe", le_d1w, 1'b1);
    chk("en_new_s0", le_d1i, 8'hAA);

    // Reset in the middle of a read burst
    clear_modes();
    rmode = 1'b1; di0_len = 32'd4; di1_read_rdy = 1'b1;
    tick();
    di0_read_req = 1'b1;
    tick();
    di0_read_req = 1'b0;
    tick();
    chk("rst_mid_read_up", le_d1r, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_rreq", le_rreq, 1'b0);
    chk("rst_mid_d1r", le_d1r, 1'b0);
    chk("rst_mid_rrdy", le_rrdy, 1'b0);
    chk("rst_mid_cnt", le_cnt, 32'd0);
    tick();
    reset = 1'b0;

    // Zero-length write: word taken and discarded
    rmode = 1'b0; wmode = 1'b1; di0_len = 32'd0;
    tick();
    chk("len0_wrdy", le_wrdy, 1'b1);
    di0_write = 1'b1;
    tick();
    di0_write = 1'b0;
    chk("len0_busy", le_wrdy, 1'b0);
    chk("len0_no_strobe_a", le_d1w, 1'b0);
    tick();
    chk("len0_no_strobe_b", le_d1w, 1'b0);
    chk("len0_back_rdy", le_wrdy, 1'b1);
    chk("len0_done", le_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
